// File: rtl/remem_pkg.sv
// -----------------------------------------------------------------------------
// remem_pkg
// Shared definitions for the memristor-array sequencer (mem_controller_v3)
// and its instruction decoder (remem_decode): opcode / sub-op / function
// codes, the controller state type and a one-hot row helper.
//
// Optional build macro: MEM_WRITE_VERIFY_EN adds the WR_VERIFY state.
// -----------------------------------------------------------------------------
package remem_pkg;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_REMEM = 3'b001;
    localparam logic [2:0] OP_RLOAD = 3'b011;
    localparam logic [2:0] OP_LW    = 3'b100;
    localparam logic [2:0] OP_SW    = 3'b101;
    localparam logic [2:0] OP_BEQ   = 3'b110;

    localparam logic [1:0] SUB_LOGIC = 2'b00;
    localparam logic [1:0] SUB_WRITE = 2'b01;

    localparam logic [1:0] FN_OR  = 2'b00;
    localparam logic [1:0] FN_AND = 2'b01;
    localparam logic [1:0] FN_XOR = 2'b10;

    localparam logic [15:0] NOP_INSTR = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HOLD     = 3'd1,
        ST_WR_RESET = 3'd2,
        ST_WR_SET   = 3'd3
`ifdef MEM_WRITE_VERIFY_EN
        ,
        ST_WR_VERIFY = 3'd4
`endif
    } state_e;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        logic [7:0] r;
        r      = 8'h00;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/remem_decode.sv
// -----------------------------------------------------------------------------
// remem_decode
// Combinational decode of the E-stage instruction into in-memory op classes.
//
// Ports:
//   instruction  in  16  E-stage instruction (0xFFFF = bubble)
//   is_load      out 1   RLOAD  (op 011)
//   is_logic     out 1   RLOGIC (op 001, [6:5]=00)
//   is_write     out 1   RWRITE (op 001, [6:5]=01)
//   row_a        out 3   RLOGIC row A ([12:10]), else the single row ([2:0])
//   row_b        out 3   RLOGIC row B ([9:7])
//   fn           out 2   combine function; code 11 folds to OR
// -----------------------------------------------------------------------------
module remem_decode
    import remem_pkg::*;
(
    input  logic [15:0] instruction,
    output logic        is_load,
    output logic        is_logic,
    output logic        is_write,
    output logic [2:0]  row_a,
    output logic [2:0]  row_b,
    output logic [1:0]  fn
);

    logic [2:0] opcode;
    logic [1:0] sub;

    always_comb begin
        opcode   = instruction[15:13];
        sub      = instruction[6:5];
        is_load  = (opcode == OP_RLOAD);
        is_logic = (opcode == OP_REMEM) && (sub == SUB_LOGIC);
        is_write = (opcode == OP_REMEM) && (sub == SUB_WRITE);
        row_a    = is_logic ? instruction[12:10] : instruction[2:0];
        row_b    = instruction[9:7];
        fn       = (instruction[4:3] == 2'b11) ? FN_OR : instruction[4:3];
    end

endmodule

// File: rtl/mem_controller_v3.sv
// -----------------------------------------------------------------------------
// mem_controller_v3
// Sequencer between the CPU Execute stage and the 8x8 memristor array.
// Accepts RLOAD / RLOGIC / RWRITE from IDLE, drives registered row selects,
// column enables, write data and gate-mode strobes, and requests a stall
// while busy or during multi-phase writes.
//
// Ports:
//   clk, rst_n (async, active-low)
//   instruction[15:0], in_data[7:0], in_buffer_data[7:0]    inputs
//   out_data_sel_1/2[7:0], control[7:0], word[7:0]           registered
//   read_or_gate, and_gate, xor_gate                         registered
//   STALL                                                    combinational
//
// Optional build macro: MEM_WRITE_VERIFY_EN (read-back verify with retries;
// otherwise in_buffer_data and MAX_RETRY are unused).
// -----------------------------------------------------------------------------
module mem_controller_v3
    import remem_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int WRITE_PULSE = 1,
    parameter int MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instruction,
    input  logic [7:0]  in_data,
    input  logic [7:0]  in_buffer_data,
    output logic [7:0]  out_data_sel_1,
    output logic [7:0]  out_data_sel_2,
    output logic [7:0]  control,
    output logic [7:0]  word,
    output logic        read_or_gate,
    output logic        and_gate,
    output logic        xor_gate,
    output logic        STALL
);

    localparam int CNT_MAX = (HOLD_CYCLES > WRITE_PULSE) ? HOLD_CYCLES : WRITE_PULSE;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    // Counters load N-1 and count down to 0, giving N cycles per phase.
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(WRITE_PULSE - 1);

    logic       dec_load, dec_logic, dec_write, dec_op;
    logic [2:0] dec_row_a, dec_row_b;
    logic [1:0] dec_fn;

    remem_decode u_decode (
        .instruction (instruction),
        .is_load     (dec_load),
        .is_logic    (dec_logic),
        .is_write    (dec_write),
        .row_a       (dec_row_a),
        .row_b       (dec_row_b),
        .fn          (dec_fn)
    );

    assign dec_op = dec_load | dec_logic | dec_write;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       row_a_q, row_a_d, row_b_q, row_b_d;
    logic [1:0]       fn_q, fn_d;
    logic             is_logic_q, is_logic_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       sel1_d, sel2_d, ctl_d, word_d;
    logic             ro_d, and_d, xor_d;

`ifdef MEM_WRITE_VERIFY_EN
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RETRY_W-1:0] retry_q, retry_d;
`else
    // Verify path compiled out: read-back bus and retry limit intentionally unused.
    logic unused_verify;
    assign unused_verify = ^{in_buffer_data, 32'(MAX_RETRY)};
`endif

    // Busy states block new ops; writes stall even on their own accept cycle.
    assign STALL = (state_q == ST_IDLE) ? dec_write
                                        : (dec_op || (state_q != ST_HOLD));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_a_d    = row_a_q;
        row_b_d    = row_b_q;
        fn_d       = fn_q;
        is_logic_d = is_logic_q;
        data_d     = data_q;
`ifdef MEM_WRITE_VERIFY_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (dec_op) begin
                    row_a_d    = dec_row_a;
                    row_b_d    = dec_row_b;
                    fn_d       = dec_fn;
                    is_logic_d = dec_logic;
                    data_d     = in_data;
`ifdef MEM_WRITE_VERIFY_EN
                    retry_d    = '0;
`endif
                    if (dec_write) begin
                        state_d = ST_WR_RESET;
                        cnt_d   = PULSE_LOAD;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_WR_RESET: begin
                if (cnt_q == '0) begin
                    state_d = ST_WR_SET;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WR_SET: begin
                if (cnt_q == '0) begin
`ifdef MEM_WRITE_VERIFY_EN
                    state_d = ST_WR_VERIFY;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef MEM_WRITE_VERIFY_EN
            ST_WR_VERIFY: begin
                // Give up after MAX_RETRY rewrites even if the cell never reads back.
                if ((in_buffer_data == data_q) || (retry_q == RETRY_W'(MAX_RETRY))) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WR_RESET;
                    cnt_d   = PULSE_LOAD;
                    retry_d = retry_q + 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Outputs are a function of the state being entered, so they are
        // valid in the very cycle that state is occupied.
        sel1_d = 8'h00;
        sel2_d = 8'h00;
        ctl_d  = 8'h00;
        word_d = 8'h00;
        ro_d   = 1'b0;
        and_d  = 1'b0;
        xor_d  = 1'b0;
        case (state_d)
            ST_HOLD: begin
                sel1_d = onehot8(row_a_d);
                if (is_logic_d) begin
                    sel2_d = onehot8(row_b_d);
                    case (fn_d)
                        FN_AND:  and_d = 1'b1;
                        FN_XOR:  xor_d = 1'b1;
                        default: ro_d  = 1'b1;
                    endcase
                end else begin
                    ro_d = 1'b1;
                end
            end
            ST_WR_RESET: begin
                sel1_d = onehot8(row_a_d);
                ctl_d  = 8'hFF;
            end
            ST_WR_SET: begin
                sel1_d = onehot8(row_a_d);
                ctl_d  = data_d;
                word_d = data_d;
            end
`ifdef MEM_WRITE_VERIFY_EN
            ST_WR_VERIFY: begin
                sel1_d = onehot8(row_a_d);
                ro_d   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            row_a_q        <= '0;
            row_b_q        <= '0;
            fn_q           <= '0;
            is_logic_q     <= 1'b0;
            data_q         <= '0;
            out_data_sel_1 <= '0;
            out_data_sel_2 <= '0;
            control        <= '0;
            word           <= '0;
            read_or_gate   <= 1'b0;
            and_gate       <= 1'b0;
            xor_gate       <= 1'b0;
`ifdef MEM_WRITE_VERIFY_EN
            retry_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            row_a_q        <= row_a_d;
            row_b_q        <= row_b_d;
            fn_q           <= fn_d;
            is_logic_q     <= is_logic_d;
            data_q         <= data_d;
            out_data_sel_1 <= sel1_d;
            out_data_sel_2 <= sel2_d;
            control        <= ctl_d;
            word           <= word_d;
            read_or_gate   <= ro_d;
            and_gate       <= and_d;
            xor_gate       <= xor_d;
`ifdef MEM_WRITE_VERIFY_EN
            retry_q        <= retry_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_controller_v3.sv
module tb_mem_controller_v3;

    localparam int HC = 2;
    localparam int WP = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instruction;
    logic [7:0]  in_data;
    logic [7:0]  in_buffer_data;
    logic [7:0]  out_data_sel_1, out_data_sel_2, control, word;
    logic        read_or_gate, and_gate, xor_gate, STALL;

    always #5 clk = ~clk;

    mem_controller_v3 #(
        .HOLD_CYCLES (HC),
        .WRITE_PULSE (WP),
        .MAX_RETRY   (3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instruction    (instruction),
        .in_data        (in_data),
        .in_buffer_data (in_buffer_data),
        .out_data_sel_1 (out_data_sel_1),
        .out_data_sel_2 (out_data_sel_2),
        .control        (control),
        .word           (word),
        .read_or_gate   (read_or_gate),
        .and_gate       (and_gate),
        .xor_gate       (xor_gate),
        .STALL          (STALL)
    );

    // Reference model: a queue of the output frames still to be shown.
    // Head = what the array sees this cycle; empty queue = controller idle.
    typedef struct packed {
        logic [7:0] s1, s2, ctl, wd;
        logic       ro, an, xo, wr;
    } frame_t;

    frame_t q[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    function automatic logic [7:0] bit_of(input int r);
        return 8'(1) << r;
    endfunction

    // 0 = not an op, 1 = RLOAD, 2 = RLOGIC, 3 = RWRITE
    function automatic int kind_of(input logic [15:0] ins);
        int op, sub;
        op  = int'(ins[15:13]);
        sub = int'(ins[6:5]);
        if (op == 3)             return 1;
        if (op == 1 && sub == 0) return 2;
        if (op == 1 && sub == 1) return 3;
        return 0;
    endfunction

    task automatic model_accept(input logic [15:0] ins, input logic [7:0] d);
        frame_t f;
        f = '0;
        case (kind_of(ins))
            1: begin
                f.s1 = bit_of(int'(ins[2:0]));
                f.ro = 1'b1;
                repeat (HC) q.push_back(f);
            end
            2: begin
                f.s1 = bit_of(int'(ins[12:10]));
                f.s2 = bit_of(int'(ins[9:7]));
                case (int'(ins[4:3]))
                    1:       f.an = 1'b1;
                    2:       f.xo = 1'b1;
                    default: f.ro = 1'b1;
                endcase
                repeat (HC) q.push_back(f);
            end
            3: begin
                f.s1  = bit_of(int'(ins[2:0]));
                f.wr  = 1'b1;
                f.ctl = 8'hFF;
                f.wd  = 8'h00;
                repeat (WP) q.push_back(f);
                f.ctl = d;
                f.wd  = d;
                repeat (WP) q.push_back(f);
            end
            default: ;
        endcase
    endtask

    // Advance the model across one rising edge using the pre-edge inputs.
    task automatic tick();
        bit     idle;
        frame_t junk;
        @(posedge clk);
        if (rst_n) begin
            idle = (q.size() == 0);
            if (!idle) junk = q.pop_front();
            if (idle) model_accept(instruction, in_data);
        end
    endtask

    task automatic check(input string tag);
        frame_t      e;
        logic        es;
        logic [35:0] obs, exp;
        e  = (q.size() == 0) ? frame_t'(0) : q[0];
        es = (q.size() == 0) ? (kind_of(instruction) == 3)
                             : (e.wr || (kind_of(instruction) != 0));
        exp = {e.s1, e.s2, e.ctl, e.wd, e.ro, e.an, e.xo, es};
        obs = {out_data_sel_1, out_data_sel_2, control, word,
               read_or_gate, and_gate, xor_gate, STALL};
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_check(input logic [15:0] ins, input logic [7:0] d, input string tag);
        @(negedge clk);
        instruction = ins;
        in_data     = d;
        #1;
        check(tag);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] ins;
        int          r;
        ins = 16'($urandom);
        case ($urandom_range(0, 9))
            0, 1, 2: ins = 16'hFFFF;
            3: ins[15:13] = 3'b011;
            4: begin ins[15:13] = 3'b001; ins[6:5] = 2'b00; end
            5: begin ins[15:13] = 3'b001; ins[6:5] = 2'b01; end
            6: begin ins[15:13] = 3'b001; ins[6]   = 1'b1;  end
            7: begin
                r = int'($urandom_range(0, 4));
                ins[15:13] = (r == 0) ? 3'b000 : (r == 1) ? 3'b010 : 3'(r + 2);
            end
            default: ;
        endcase
        return ins;
    endfunction

    initial begin
        rst_n          = 1'b0;
        instruction    = 16'hFFFF;
        in_data        = 8'h00;
        in_buffer_data = 8'h00;

        // Reset state
        @(negedge clk);
        #1;
        check("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive_check(16'hFFFF, 8'h00, "idle_nop0"); tick();
        drive_check(16'hFFFF, 8'h00, "idle_nop1"); tick();

        // RLOAD row 5
        drive_check(16'h6005, 8'h00, "rload_accept");
        check_val("rload_accept_stall", {7'd0, STALL}, 8'h00);
        tick();
        drive_check(16'hFFFF, 8'h00, "rload_h1");
        check_val("rload_sel1", out_data_sel_1, 8'h20);
        check_val("rload_ro", {7'd0, read_or_gate}, 8'h01);
        tick();
        drive_check(16'hFFFF, 8'h00, "rload_h2"); tick();
        drive_check(16'hFFFF, 8'h00, "rload_done");
        check_val("rload_done_sel1", out_data_sel_1, 8'h00);
        tick();

        // RLOGIC XOR rows 1,3
        drive_check(16'h2590, 8'h00, "xor_accept"); tick();
        drive_check(16'hFFFF, 8'h00, "xor_h1");
        check_val("xor_sel1", out_data_sel_1, 8'h02);
        check_val("xor_sel2", out_data_sel_2, 8'h08);
        check_val("xor_strobes", {5'd0, read_or_gate, and_gate, xor_gate}, 8'h01);
        tick();
        drive_check(16'hFFFF, 8'h00, "xor_h2"); tick();
        drive_check(16'hFFFF, 8'h00, "xor_done"); tick();

        // RWRITE 0xA5 to row 2
        drive_check(16'h2822, 8'hA5, "wr_accept");
        check_val("wr_accept_stall", {7'd0, STALL}, 8'h01);
        tick();
        drive_check(16'hFFFF, 8'h3C, "wr_reset");
        check_val("wr_reset_ctl", control, 8'hFF);
        check_val("wr_reset_word", word, 8'h00);
        check_val("wr_reset_sel1", out_data_sel_1, 8'h04);
        tick();
        drive_check(16'hFFFF, 8'h3C, "wr_set");
        check_val("wr_set_ctl", control, 8'hA5);
        check_val("wr_set_word", word, 8'hA5);
        tick();
        drive_check(16'hFFFF, 8'h00, "wr_done");
        check_val("wr_done_stall", {7'd0, STALL}, 8'h00);
        tick();

        // Collision: RLOGIC arrives while RLOAD holds
        drive_check(16'h6005, 8'h00, "col_load"); tick();
        drive_check(16'h2590, 8'h00, "col_stall1");
        check_val("col_stall1_v", {7'd0, STALL}, 8'h01);
        tick();
        drive_check(16'h2590, 8'h00, "col_stall2");
        check_val("col_stall2_v", {7'd0, STALL}, 8'h01);
        tick();
        drive_check(16'h2590, 8'h00, "col_accept");
        check_val("col_accept_stall", {7'd0, STALL}, 8'h00);
        tick();
        drive_check(16'hFFFF, 8'h00, "col_xor");
        check_val("col_xor_strobe", {7'd0, xor_gate}, 8'h01);
        tick();
        drive_check(16'hFFFF, 8'h00, "col_h2"); tick();
        drive_check(16'hFFFF, 8'h00, "col_done"); tick();

        // Reset asserted during WR_SET
        drive_check(16'h2822, 8'h5A, "rstw_accept"); tick();
        drive_check(16'hFFFF, 8'h00, "rstw_reset"); tick();
        @(negedge clk);
        instruction = 16'hFFFF;
        #1;
        check_val("rstw_in_set", control, 8'h5A);
        rst_n = 1'b0;
        q.delete();
        #1;
        check("rstw_abort");
        check_val("rstw_abort_stall", {7'd0, STALL}, 8'h00);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive_check(16'hFFFF, 8'h00, "rstw_idle0"); tick();
        drive_check(16'hFFFF, 8'h00, "rstw_idle1"); tick();

        // Randomized traffic, with occasional asynchronous reset pulses
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            rst_n          = ($urandom_range(0, 63) != 0);
            instruction    = rand_instr();
            in_data        = 8'($urandom);
            in_buffer_data = 8'($urandom);
            if (!rst_n) q.delete();
            #1;
            check("random");
            check_val("strobe_excl",
                      {7'd0, ($countones({read_or_gate, and_gate, xor_gate}) <= 1)}, 8'h01);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_controller_v3.md
Name: mem_controller_v3

Overview:
- Sequencer between the pipelined 16-bit CPU's Execute stage and the 8x8 virtual memristor array (rows x bit-columns).
- Decodes the E-stage instruction for in-memory ops (row load, row write, in-array OR/AND/XOR) and captures each accepted op.
- Drives the array's row selects, write data, column enables and gate-mode strobes as registered outputs.
- Raises STALL while it cannot accept a new op or while a multi-phase write is running.

Parameters:
- HOLD_CYCLES, 2, cycles read/logic outputs stay driven after issue so the result reaches the W stage (>=1).
- WRITE_PULSE, 1, cycles per write phase (RESET and SET) (>=1).
- MAX_RETRY, 3, rewrite attempts when MEM_WRITE_VERIFY_EN is defined.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instruction  in  16  E-stage instruction (0xFFFF = bubble)
- in_data  in  8  register operand (reg[9:7] low byte) for row write
- in_buffer_data  in  8  array read-out bus
- out_data_sel_1  out  8  one-hot row select A
- out_data_sel_2  out  8  one-hot row select B
- control  out  8  per-column write enable
- word  out  8  data driven onto columns during write
- read_or_gate  out  1  read / OR-combine mode
- and_gate  out  1  AND-combine mode
- xor_gate  out  1  XOR-combine mode
- STALL  out  1  pipeline stall request (combinational)

Behaviour:
- Decode uses opcode = instruction[15:13].
  - RLOAD: op 011; row = [2:0].
  - RLOGIC: op 001 with [6:5]=00; rowA = [12:10], rowB = [9:7], fn = [4:3] (00 OR, 01 AND, 10 XOR, 11 treated as OR).
  - RWRITE: op 001 with [6:5]=01; row = [2:0]; data = in_data.
  - Everything else is ignored, including op 001 with [6:5]=1x, all other opcodes, and 0xFFFF.
- States: IDLE, HOLD, WR_RESET, WR_SET (plus WR_VERIFY with the optional feature). Counter width covers max(HOLD_CYCLES, WRITE_PULSE).
- Reset (async, rst_n=0): state IDLE, counters 0, all outputs 0, STALL=0.
- Accept: only in IDLE, at the rising edge where instruction decodes as an op. Row index, fn and in_data are captured at that edge.
- RLOAD accept:
  - Next cycle: out_data_sel_1 = onehot(row), out_data_sel_2 = 0, read_or_gate = 1, control = 0, word = 0.
  - State goes to HOLD for HOLD_CYCLES cycles, then IDLE with all outputs cleared to 0 on the same edge.
- RLOGIC accept:
  - Next cycle: out_data_sel_1 = onehot(rowA), out_data_sel_2 = onehot(rowB), exactly one strobe per fn.
  - rowA == rowB is legal; both selects carry the same bit.
  - HOLD timing is identical to RLOAD.
- RWRITE accept:
  - WR_RESET for WRITE_PULSE cycles: out_data_sel_1 = onehot(row), control = 0xFF, word = 0x00.
  - WR_SET for WRITE_PULSE cycles: same select, control = data, word = data.
  - Then IDLE, outputs 0.
  - All gate strobes are 0 throughout the write.
- STALL is 1 when any of the following holds:
  - state is IDLE and instruction decodes as RWRITE;
  - state is a write state (WR_*);
  - state is not IDLE and instruction decodes as any op (the op is not accepted).
- STALL is 0 otherwise. Read/logic accepted from IDLE does not stall.
- An op presented during the last HOLD cycle is stalled; it is accepted on the following edge, when state is IDLE. Back-to-back issue therefore costs 1 bubble.
- Mode-strobe exclusivity: at most one of read_or_gate / and_gate / xor_gate is high in any cycle; control is nonzero only in write states.
- rst_n asserted mid-write aborts the operation immediately. Outputs go to 0; there is no partial-write recovery.

Optional Feature:
- MEM_WRITE_VERIFY_EN defined:
  - After WR_SET, enter WR_VERIFY for 1 cycle: out_data_sel_1 = onehot(row), read_or_gate = 1, STALL = 1.
  - If in_buffer_data == data, go to IDLE.
  - Otherwise repeat WR_RESET/WR_SET, up to MAX_RETRY times, then go to IDLE regardless.
- Undefined: no WR_VERIFY state and in_buffer_data is unused.

Decomposition:
- Shared package remem_pkg:
  - opcode constants OP_RTYPE=000, OP_REMEM=001, OP_RLOAD=011, OP_LW=100, OP_SW=101, OP_BEQ=110;
  - sub-op codes SUB_LOGIC=00, SUB_WRITE=01;
  - fn codes FN_OR, FN_AND, FN_XOR;
  - state enum;
  - NOP_INSTR=16'hFFFF.
- One natural sub-module: remem_decode (combinational instruction -> is_load/is_logic/is_write, row fields, fn).

Test Plan:
- Reset: drive rst_n=0 mid-WR_SET -> all outputs 0 and STALL=0 immediately; after release, instruction=0xFFFF -> stays IDLE.
- RLOAD: instruction 0x6005 (op 011, row 5) -> next cycle out_data_sel_1=0x20, read_or_gate=1, STALL=0; outputs return to 0 after 2 cycles.
- RLOGIC XOR: instruction 0x2590 (op 001, rowA=1, rowB=3, fn=10) -> sel_1=0x02, sel_2=0x08, xor_gate=1, others 0.
- RWRITE: in_data=0xA5, instruction 0x2822 (op 001, sub 01, row 2) -> STALL=1 in the accept cycle.
  - Then 1 cycle of control=0xFF/word=0x00/sel_1=0x04.
  - Then 1 cycle of control=0xA5/word=0xA5.
  - Then IDLE with STALL=0; 2 write cycles total.
- Collision: RLOAD accepted, RLOGIC presented the next cycle -> STALL=1 for 2 cycles, RLOGIC outputs appear after HOLD ends.
- Verify (MEM_WRITE_VERIFY_EN): in_buffer_data forced to 0x00 after writing 0xA5 -> write repeats 3 times, then IDLE, STALL drops.
